// File: rtl/posit_pkg.sv
// posit_pkg: shared sizing and field-position helpers for the posit multiplier.
// Each helper is a function of the posit width N and the exponent width ES, so
// every module derives the same widths from the same two parameters.
//   posit_ew    : exponent field width of the unpacked result
//   posit_fw    : fraction field width of the unpacked result
//   posit_fs    : maximum fraction bits of a decoded posit
//   posit_bias  : exponent bias of the unpacked result
//   posit_*_idx : bit positions of the flags inside the unpacked result
package posit_pkg;

  function automatic int posit_ew(input int n, input int es);
    return es + $clog2(n) + 2;
  endfunction

  function automatic int posit_fw(input int n);
    return 2 * n - 3;
  endfunction

  function automatic int posit_fs(input int n, input int es);
    return n - 3 - es;
  endfunction

  function automatic int posit_bias(input int n, input int es);
    return (1 << (posit_ew(n, es) - 1)) - 1;
  endfunction

  // Unpacked result, MSB first: {inf, zero, sign, exp[EW-1:0], frac[FW-1:0]}
  function automatic int posit_exp_lsb(input int n);
    return posit_fw(n);
  endfunction

  function automatic int posit_sign_idx(input int n, input int es);
    return posit_ew(n, es) + posit_fw(n);
  endfunction

  function automatic int posit_zero_idx(input int n, input int es);
    return posit_ew(n, es) + posit_fw(n) + 1;
  endfunction

  function automatic int posit_inf_idx(input int n, input int es);
    return posit_ew(n, es) + posit_fw(n) + 2;
  endfunction

  function automatic int posit_res_w(input int n, input int es);
    return posit_ew(n, es) + posit_fw(n) + 3;
  endfunction

endpackage

// File: rtl/posit_decode.sv
// posit_decode: combinational decode of one posit into its fields.
//   posit_i : N-bit posit
//   nar_o   : posit is NaR (1 followed by zeros)
//   zero_o  : posit is zero
//   sign_o  : sign bit
//   scale_o : k*2^ES + e, two's complement, EW bits
//   sig_o   : significand 1.f with FS fraction bits (missing bits are zero)
module posit_decode
  import posit_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 0
) (
  input  logic [N-1:0]               posit_i,
  output logic                       nar_o,
  output logic                       zero_o,
  output logic                       sign_o,
  output logic [posit_ew(N, ES)-1:0] scale_o,
  output logic [posit_fs(N, ES):0]   sig_o
);

  localparam int EW  = posit_ew(N, ES);
  localparam int FS  = posit_fs(N, ES);
  localparam int ESW = (ES > 0) ? ES : 1;

  logic [N-1:0]   mag;
  logic [N-2:0]   body;
  logic [N-2:0]   tail;
  logic           rbit;
  logic           stop;
  logic [EW-1:0]  run;
  logic [EW-1:0]  k;
  logic [ESW-1:0] e;
  logic           unused_bits;

  always_comb begin
    mag  = posit_i[N-1] ? -posit_i : posit_i;
    body = mag[N-2:0];
    rbit = body[N-2];
    run  = '0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (body[i] == rbit)) run = run + EW'(1);
      else stop = 1'b1;
    end
    k    = rbit ? (run - EW'(1)) : (-run);
    // Drop the regime run and its terminator; exponent then fraction follow
    // left-aligned. The two LSBs of tail are always shifted-in zeros.
    tail = body << (run + EW'(1));
    e    = (ES > 0) ? tail[N-2 -: ESW] : '0;
    scale_o = (k << ES) + EW'(e);
    sig_o   = {1'b1, tail[N-2-ES -: FS]};
    sign_o  = posit_i[N-1];
    zero_o  = (posit_i == '0);
    nar_o   = posit_i[N-1] && (posit_i[N-2:0] == '0);
    unused_bits = ^{tail[1:0], mag[N-1]};
  end

endmodule

// File: rtl/posit_mult_pipe.sv
// posit_mult_pipe: exact 3-stage posit multiplier producing an unpacked result.
//   S1 decode both operands, S2 significand multiply + scale add,
//   S3 normalise and format. One global stall: all stages move together.
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : operand handshake (left_posit, right_posit)
//   out_valid / out_ready   : result handshake
//   result                  : {inf, zero, sign, exp, frac}, zero when idle
module posit_mult_pipe
  import posit_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0]                  left_posit,
  input  logic [N-1:0]                  right_posit,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [posit_res_w(N, ES)-1:0] result
);

  localparam int EW       = posit_ew(N, ES);
  localparam int FW       = posit_fw(N);
  localparam int FS       = posit_fs(N, ES);
  localparam int BIAS     = posit_bias(N, ES);
  localparam int RW       = posit_res_w(N, ES);
  localparam int SGW      = FS + 1;
  localparam int PW       = 2 * SGW;
  localparam int FPAD     = FW - (PW - 1);
  localparam int EXP_LSB  = posit_exp_lsb(N);
  localparam int SIGN_IDX = posit_sign_idx(N, ES);
  localparam int ZERO_IDX = posit_zero_idx(N, ES);
  localparam int INF_IDX  = posit_inf_idx(N, ES);

  logic           advance;
  logic           l_nar, l_zero, l_sign, r_nar, r_zero, r_sign;
  logic [EW-1:0]  l_scale, r_scale;
  logic [SGW-1:0] l_sig, r_sig;

  logic           s1_valid_q, s1_nar_q, s1_zero_q, s1_sign_q;
  logic [EW-1:0]  s1_lscale_q, s1_rscale_q;
  logic [SGW-1:0] s1_lsig_q, s1_rsig_q;

  logic           s2_valid_q, s2_nar_q, s2_zero_q, s2_sign_q;
  logic [EW-1:0]  s2_ssum_q;
  logic [PW-1:0]  s2_prod_q;

  logic           s3_valid_q;
  logic [RW-1:0]  result_q, result_d;

  logic           ge2;
  logic [PW-1:0]  pn;
  logic [FW-1:0]  mfrac;
  logic [EW-1:0]  exp_pos;
  logic           unused_msb;

  posit_decode #(.N(N), .ES(ES)) u_dec_l (
    .posit_i (left_posit),
    .nar_o   (l_nar),
    .zero_o  (l_zero),
    .sign_o  (l_sign),
    .scale_o (l_scale),
    .sig_o   (l_sig)
  );

  posit_decode #(.N(N), .ES(ES)) u_dec_r (
    .posit_i (right_posit),
    .nar_o   (r_nar),
    .zero_o  (r_zero),
    .sign_o  (r_sign),
    .scale_o (r_scale),
    .sig_o   (r_sig)
  );

  assign advance   = !s3_valid_q || out_ready;
  // Nothing is taken while reset is applied.
  assign in_ready  = !rst && advance;
  assign out_valid = s3_valid_q;
  assign result    = result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      result_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      result_q   <= s2_valid_q ? result_d : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_nar_q    <= l_nar | r_nar;
      s1_zero_q   <= l_zero | r_zero;
      s1_sign_q   <= l_sign ^ r_sign;
      s1_lscale_q <= l_scale;
      s1_rscale_q <= r_scale;
      s1_lsig_q   <= l_sig;
      s1_rsig_q   <= r_sig;
      s2_nar_q    <= s1_nar_q;
      s2_zero_q   <= s1_zero_q;
      s2_sign_q   <= s1_sign_q;
      s2_ssum_q   <= s1_lscale_q + s1_rscale_q;
      s2_prod_q   <= PW'(s1_lsig_q) * PW'(s1_rsig_q);
    end
  end

  always_comb begin
    ge2     = s2_prod_q[PW-1];
    pn      = ge2 ? s2_prod_q : (s2_prod_q << 1);
    mfrac   = {pn[PW-2:0], {FPAD{1'b0}}};
    exp_pos = s2_ssum_q + EW'(BIAS) + EW'(ge2);
    unused_msb = pn[PW-1];
    result_d = '0;
    if (s2_nar_q) begin
      result_d[INF_IDX] = 1'b1;
    end else if (s2_zero_q) begin
      result_d[ZERO_IDX] = 1'b1;
    end else begin
      result_d[SIGN_IDX] = s2_sign_q;
      if (s2_sign_q && (mfrac == '0)) begin
        // -2^s is written as -(2 - 0) * 2^(s-1)
        result_d[EXP_LSB +: EW] = exp_pos - EW'(1);
      end else if (s2_sign_q) begin
        result_d[EXP_LSB +: EW] = exp_pos;
        result_d[FW-1:0]        = -mfrac;
      end else begin
        result_d[EXP_LSB +: EW] = exp_pos;
        result_d[FW-1:0]        = mfrac;
      end
    end
  end

endmodule

// File: tb/tb_posit_mult_pipe.sv
module tb_posit_mult_pipe;

  localparam int N    = 8;
  localparam int ES   = 0;
  localparam int EW   = 5;
  localparam int FW   = 13;
  localparam int RW   = 21;
  localparam int BIAS = 15;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  left_posit, right_posit;
  logic [RW-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [RW-1:0] exp_q[$];

  always #5 clk = ~clk;

  posit_mult_pipe #(.N(N), .ES(ES)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .left_posit  (left_posit),
    .right_posit (right_posit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic real pow2(input int s);
    real v;
    v = 1.0;
    if (s >= 0) for (int j = 0; j < s; j++) v = v * 2.0;
    else        for (int j = 0; j < -s; j++) v = v / 2.0;
    return v;
  endfunction

  // Real value of a (non-NaR) posit, read bit by bit from the definition.
  function automatic real pval(input logic [N-1:0] p);
    logic [N-1:0] a;
    int  i, run, k, e;
    logic r;
    real f, w, v;
    if (p == '0) return 0.0;
    a = p[N-1] ? -p : p;
    i = N - 2;
    r = a[N-2];
    run = 0;
    while (i >= 0 && a[i] == r) begin
      run++;
      i--;
    end
    k = r ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin
      if (a[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    v = f * pow2(k * (1 << ES) + e);
    return p[N-1] ? -v : v;
  endfunction

  function automatic logic [RW-1:0] encode(input real v);
    logic [RW-1:0] res;
    logic   neg;
    real    m;
    int     e;
    longint fi;
    neg = (v < 0.0);
    m = neg ? -v : v;
    e = 0;
    if (!neg) begin
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      fi = longint'((m - 1.0) * pow2(FW));
    end else begin
      while (m > 2.0)  begin m = m / 2.0; e++; end
      while (m <= 1.0) begin m = m * 2.0; e--; end
      fi = longint'((2.0 - m) * pow2(FW));
    end
    res = '0;
    res[RW-3]      = neg;
    res[FW +: EW]  = EW'(e + BIAS);
    res[FW-1:0]    = fi[FW-1:0];
    return res;
  endfunction

  function automatic logic [RW-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a == NAR || b == NAR) return {1'b1, {(RW-1){1'b0}}};
    if (a == '0 || b == '0)   return {2'b01, {(RW-2){1'b0}}};
    return encode(pval(a) * pval(b));
  endfunction

  // One clock cycle: drive inputs after the falling edge, then observe the
  // handshakes that the next rising edge will complete.
  task automatic step(input logic iv, input logic [N-1:0] l, input logic [N-1:0] r,
                      input logic ordy, input logic rs, output logic acc);
    @(negedge clk);
    rst = rs;
    in_valid = iv;
    left_posit = l;
    right_posit = r;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (!out_valid) check("idle_result_zero", 32'(result), 32'h0);
    if (acc) exp_q.push_back(model(l, r));
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("unexpected_output", 32'(out_valid), 32'h0);
      else                   check("product", 32'(result), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n0, idx;
    logic [15:0] pr;
    logic [N-1:0] sl[4];
    logic [N-1:0] sr[4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    left_posit = '0; right_posit = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_result",    32'(result),    32'h0);
    check("reset_in_ready",  32'(in_ready),  32'h1);

    // latency: 0.5 x 2 = 1.0
    step(1'b1, 8'h20, 8'h60, 1'b1, 1'b0, acc);
    check("lat_accept", 32'(acc), 32'h1);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("lat_t1", 32'(out_valid), 32'h0);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("lat_t2", 32'(out_valid), 32'h0);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("lat_t3_valid",  32'(out_valid), 32'h1);
    check("lat_t3_result", 32'(result),    32'h1E000);

    // back-to-back
    step(1'b1, 8'h66, 8'hDB, 1'b1, 1'b0, acc);
    step(1'b1, 8'h8F, 8'h3A, 1'b1, 1'b0, acc);
    step(1'b1, 8'hB2, 8'hE2, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("b2b_0_valid", 32'(out_valid), 32'h1);
    check("b2b_0",       32'(result),    32'h5ED20);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("b2b_1_valid", 32'(out_valid), 32'h1);
    check("b2b_1",       32'(result),    32'h63F60);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("b2b_2_valid", 32'(out_valid), 32'h1);
    check("b2b_2",       32'(result),    32'h1CB20);

    // special operands
    step(1'b1, 8'h00, 8'h66, 1'b1, 1'b0, acc);
    step(1'b1, 8'h80, 8'h3A, 1'b1, 1'b0, acc);
    step(1'b1, 8'h80, 8'h00, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("zero_x",  32'(result), 32'h80000);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("nar_x",   32'(result), 32'h100000);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("nar_x_0", 32'(result), 32'h100000);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("drained_idle", 32'(out_valid), 32'h0);

    // stall: out_ready low for 4 cycles with 4 inputs offered
    for (int j = 0; j < 4; j++) begin
      sl[j] = N'($urandom_range(255));
      sr[j] = N'($urandom_range(255));
    end
    n0 = n_out;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, sl[idx], sr[idx], (c == 0), 1'b0, acc);
      if (acc) idx++;
      if (c >= 3) begin
        check("stall_in_ready",  32'(in_ready),  32'h0);
        check("stall_out_valid", 32'(out_valid), 32'h1);
        check("stall_hold",      32'(result),    32'(model(sl[0], sr[0])));
      end
    end
    check("stall_accepted", 32'(idx), 32'd3);
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() > 0); c++) begin
      step(idx < 4, sl[idx % 4], sr[idx % 4], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    check("stall_count", 32'(n_out - n0), 32'd4);
    check("stall_empty", 32'(exp_q.size()), 32'd0);

    // reset with two products in flight
    n0 = n_out;
    step(1'b1, 8'h66, 8'h3A, 1'b1, 1'b0, acc);
    step(1'b1, 8'hB2, 8'h60, 1'b1, 1'b0, acc);
    step(1'b1, 8'h8F, 8'hDB, 1'b1, 1'b1, acc);
    check("rst_no_accept", 32'(acc), 32'h0);
    exp_q.delete();
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_result",    32'(result),    32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    repeat (6) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("rst_no_stale", 32'(n_out - n0), 32'd0);

    // every operand pair, random back-pressure
    for (int i = 0; i < 65536; i++) begin
      pr = 16'(i);
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++)
        step(1'b1, pr[15:8], pr[7:0], ($urandom_range(15) != 0), 1'b0, acc);
      if (!acc) begin
        check("accept_timeout", 32'(acc), 32'h1);
        break;
      end
    end
    for (int c = 0; c < 64 && exp_q.size() > 0; c++)
      step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
